// File: rtl/uvmt_cv32e40x_sl_trigger_entry_checker.sv
// rtl/uvmt_cv32e40x_sl_trigger_entry_checker.sv - trigger-match to debug-entry checker with per-trigger hit counters
//
// Purpose:
//   Sits downstream of the trigger-match predictor. Every non-debug retirement
//   that carries a trigger match is captured; the checker then expects the next
//   retirement to be the first debug-handler instruction with cause 2 and a dpc
//   equal to the PC of the matching instruction. Missing, mismatched, late and
//   spurious entries are flagged as single-cycle registered pulses.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   rvfi_valid_i                   retirement strobe
//   rvfi_dbg_mode_i                retired instruction executed in debug mode
//   rvfi_dbg_i[2:0]                debug cause, non-zero on first handler instruction
//   rvfi_pc_rdata_i[31:0]          PC of retired instruction
//   dpc_i[31:0]                    dpc CSR sampled at retirement
//   trigger_match_*_i[NT-1:0]      execute / load-store / exception matches
//   entry_pending_o                trigger debug entry expected, not yet seen
//   pending_mask_o[NT-1:0]         triggers captured for the pending entry
//   entry_ok_o .. spurious_err_o   result pulses, one cycle after the retirement
//   hit_cnt_o[NT*CNT_W-1:0]        saturating hit counters, trigger t at [t*CNT_W +: CNT_W]

module uvmt_cv32e40x_sl_trigger_entry_checker #(
    parameter int NUM_TRIGGERS   = 1,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rvfi_valid_i,
    input  logic                          rvfi_dbg_mode_i,
    input  logic [2:0]                    rvfi_dbg_i,
    input  logic [31:0]                   rvfi_pc_rdata_i,
    input  logic [31:0]                   dpc_i,
    input  logic [NUM_TRIGGERS-1:0]       trigger_match_execute_i,
    input  logic [NUM_TRIGGERS-1:0]       trigger_match_mem_i,
    input  logic [NUM_TRIGGERS-1:0]       trigger_match_exception_i,
    output logic                          entry_pending_o,
    output logic [NUM_TRIGGERS-1:0]       pending_mask_o,
    output logic                          entry_ok_o,
    output logic                          dpc_err_o,
    output logic                          cause_err_o,
    output logic                          missed_err_o,
    output logic                          timeout_err_o,
    output logic                          spurious_err_o,
    output logic [NUM_TRIGGERS*CNT_W-1:0] hit_cnt_o
);

    // The wait counter only has to reach TIMEOUT_CYCLES-1 before leaving WAIT_ENTRY.
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [2:0] DBG_CAUSE_TRIGGER = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_ENTRY = 2'd1,
        S_IN_DEBUG   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [TW-1:0]           r_cnt;
    logic [NUM_TRIGGERS-1:0] r_mask;
    logic [31:0]             r_exp_pc;
    logic                    r_chk_pc;

    logic r_entry_ok, r_dpc_err, r_cause_err, r_missed_err, r_timeout_err, r_spurious_err;
    logic w_entry_ok, w_dpc_err, w_cause_err, w_missed_err, w_timeout_err, w_spurious_err;

    logic [NUM_TRIGGERS-1:0] w_match;
    logic                    w_capture;
    logic                    w_dbg_entry;
    logic                    w_cause_trig;
    logic                    w_dpc_ok;
    logic                    w_timeout_hit;
    logic                    w_load;

    assign w_match       = trigger_match_execute_i | trigger_match_mem_i | trigger_match_exception_i;
    assign w_capture     = rvfi_valid_i && !rvfi_dbg_mode_i && (|w_match);
    assign w_dbg_entry   = rvfi_valid_i && rvfi_dbg_mode_i;
    assign w_cause_trig  = (rvfi_dbg_i == DBG_CAUSE_TRIGGER);
    // Exception triggers report dpc of the handler-to-be, not the matching PC,
    // so only the cause is checked for them.
    assign w_dpc_ok      = !r_chk_pc || (dpc_i == r_exp_pc);
    assign w_timeout_hit = (r_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_entry_ok     = 1'b0;
        w_dpc_err      = 1'b0;
        w_cause_err    = 1'b0;
        w_missed_err   = 1'b0;
        w_timeout_err  = 1'b0;
        w_spurious_err = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_capture) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_WAIT_ENTRY;
                end else if (w_dbg_entry) begin
                    // Non-trigger entries (haltreq, ebreak, ...) are legal here.
                    w_spurious_err = w_cause_trig;
                    w_state_nxt    = S_IN_DEBUG;
                end
            end

            S_WAIT_ENTRY: begin
                // Any retirement resolves the pending entry, even in the
                // timeout cycle, so it is checked before the timeout.
                if (w_dbg_entry) begin
                    w_state_nxt = S_IN_DEBUG;
                    if (!w_cause_trig) begin
                        w_cause_err = 1'b1;
                    end else if (w_dpc_ok) begin
                        w_entry_ok  = 1'b1;
                    end else begin
                        w_dpc_err   = 1'b1;
                    end
                end else if (rvfi_valid_i) begin
                    w_missed_err = 1'b1;
                    if (w_capture) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_timeout_hit) begin
                    w_timeout_err = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end

            S_IN_DEBUG: begin
                // The first retirement after dret is evaluated as in IDLE;
                // only a capture can result since it is not in debug mode.
                if (rvfi_valid_i && !rvfi_dbg_mode_i) begin
                    if (w_capture) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_WAIT_ENTRY;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_mask         <= '0;
            r_exp_pc       <= '0;
            r_chk_pc       <= 1'b0;
            r_entry_ok     <= 1'b0;
            r_dpc_err      <= 1'b0;
            r_cause_err    <= 1'b0;
            r_missed_err   <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_spurious_err <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_entry_ok     <= w_entry_ok;
            r_dpc_err      <= w_dpc_err;
            r_cause_err    <= w_cause_err;
            r_missed_err   <= w_missed_err;
            r_timeout_err  <= w_timeout_err;
            r_spurious_err <= w_spurious_err;

            if (w_load) begin
                r_mask   <= w_match;
                r_exp_pc <= rvfi_pc_rdata_i;
                r_chk_pc <= !(|trigger_match_exception_i);
            end

            // Counts cycles spent waiting since the last capture.
            if (w_load) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT_ENTRY) && (w_state_nxt == S_WAIT_ENTRY)) begin
                r_cnt <= r_cnt + TW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    for (genvar t = 0; t < NUM_TRIGGERS; t++) begin : g_hit
        logic [CNT_W-1:0] r_hit;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_hit <= '0;
            end else if (w_capture && w_match[t] && (r_hit != {CNT_W{1'b1}})) begin
                r_hit <= r_hit + CNT_W'(1);
            end
        end

        assign hit_cnt_o[t*CNT_W +: CNT_W] = r_hit;
    end

    assign entry_pending_o = (r_state == S_WAIT_ENTRY);
    assign pending_mask_o  = entry_pending_o ? r_mask : '0;
    assign entry_ok_o      = r_entry_ok;
    assign dpc_err_o       = r_dpc_err;
    assign cause_err_o     = r_cause_err;
    assign missed_err_o    = r_missed_err;
    assign timeout_err_o   = r_timeout_err;
    assign spurious_err_o  = r_spurious_err;

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_trigger_entry_checker.sv
// tb/tb_uvmt_cv32e40x_sl_trigger_entry_checker.sv - scoreboard bench for the trigger entry checker

module tb_uvmt_cv32e40x_sl_trigger_entry_checker;

    localparam int NT    = 2;
    localparam int TMO   = 64;
    localparam int CW    = 4;
    localparam int HMAX  = (1 << CW) - 1;

    // Pulse vector order: {ok, dpc, cause, missed, timeout, spurious}
    localparam logic [5:0] P_NONE = 6'b000000;
    localparam logic [5:0] P_OK   = 6'b100000;
    localparam logic [5:0] P_DPC  = 6'b010000;
    localparam logic [5:0] P_CAU  = 6'b001000;
    localparam logic [5:0] P_MIS  = 6'b000100;
    localparam logic [5:0] P_TMO  = 6'b000010;
    localparam logic [5:0] P_SPU  = 6'b000001;

    typedef struct packed {
        logic [5:0]    p;
        logic          pend;
        logic [NT-1:0] mask;
        logic [CW-1:0] h0;
        logic [CW-1:0] h1;
    } exp_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              rvfi_valid_i = 1'b0;
    logic              rvfi_dbg_mode_i = 1'b0;
    logic [2:0]        rvfi_dbg_i = '0;
    logic [31:0]       rvfi_pc_rdata_i = '0;
    logic [31:0]       dpc_i = '0;
    logic [NT-1:0]     trigger_match_execute_i = '0;
    logic [NT-1:0]     trigger_match_mem_i = '0;
    logic [NT-1:0]     trigger_match_exception_i = '0;
    logic              entry_pending_o;
    logic [NT-1:0]     pending_mask_o;
    logic              entry_ok_o, dpc_err_o, cause_err_o, missed_err_o, timeout_err_o, spurious_err_o;
    logic [NT*CW-1:0]  hit_cnt_o;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   e_hit0 = 0;
    int   e_hit1 = 0;

    uvmt_cv32e40x_sl_trigger_entry_checker #(
        .NUM_TRIGGERS   (NT),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .clk_i                     (clk_i),
        .rst_ni                    (rst_ni),
        .rvfi_valid_i              (rvfi_valid_i),
        .rvfi_dbg_mode_i           (rvfi_dbg_mode_i),
        .rvfi_dbg_i                (rvfi_dbg_i),
        .rvfi_pc_rdata_i           (rvfi_pc_rdata_i),
        .dpc_i                     (dpc_i),
        .trigger_match_execute_i   (trigger_match_execute_i),
        .trigger_match_mem_i       (trigger_match_mem_i),
        .trigger_match_exception_i (trigger_match_exception_i),
        .entry_pending_o           (entry_pending_o),
        .pending_mask_o            (pending_mask_o),
        .entry_ok_o                (entry_ok_o),
        .dpc_err_o                 (dpc_err_o),
        .cause_err_o               (cause_err_o),
        .missed_err_o              (missed_err_o),
        .timeout_err_o             (timeout_err_o),
        .spurious_err_o            (spurious_err_o),
        .hit_cnt_o                 (hit_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drives one cycle of inputs and records what the outputs must be after the
    // sampling edge. Hit-count expectations follow the capture rule directly.
    task automatic drive(input logic v, input logic dm, input logic [2:0] dbg,
                         input logic [31:0] pc, input logic [31:0] dpc,
                         input logic [NT-1:0] ex, input logic [NT-1:0] mem, input logic [NT-1:0] exc,
                         input logic [5:0] ep, input logic epend, input logic [NT-1:0] emask);
        exp_t e;
        logic [NT-1:0] m;
        @(negedge clk_i);
        rvfi_valid_i              = v;
        rvfi_dbg_mode_i           = dm;
        rvfi_dbg_i                = dbg;
        rvfi_pc_rdata_i           = pc;
        dpc_i                     = dpc;
        trigger_match_execute_i   = ex;
        trigger_match_mem_i       = mem;
        trigger_match_exception_i = exc;
        m = ex | mem | exc;
        if (v && !dm && (|m) && rst_ni) begin
            if (m[0] && e_hit0 < HMAX) e_hit0++;
            if (m[1] && e_hit1 < HMAX) e_hit1++;
        end
        e.p    = ep;
        e.pend = epend;
        e.mask = emask;
        e.h0   = CW'(e_hit0);
        e.h1   = CW'(e_hit1);
        q.push_back(e);
    endtask

    task automatic idle(input logic [5:0] ep, input logic epend, input logic [NT-1:0] emask);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0, 2'b00, 2'b00, 2'b00, ep, epend, emask);
    endtask

    // Non-debug retirement with no trigger match.
    task automatic plain(input logic [5:0] ep);
        drive(1'b1, 1'b0, 3'd0, 32'h0000_0100, 32'h0, 2'b00, 2'b00, 2'b00, ep, 1'b0, 2'b00);
    endtask

    task automatic dentry(input logic [2:0] cause, input logic [31:0] dpc, input logic [5:0] ep);
        drive(1'b1, 1'b1, cause, 32'h1A11_0800, dpc, 2'b00, 2'b00, 2'b00, ep, 1'b0, 2'b00);
    endtask

    always @(posedge clk_i) begin
        exp_t e;
        #1;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("pulses", {26'd0, entry_ok_o, dpc_err_o, cause_err_o, missed_err_o, timeout_err_o, spurious_err_o}, {26'd0, e.p});
            chk("pending", {31'd0, entry_pending_o}, {31'd0, e.pend});
            chk("mask", {30'd0, pending_mask_o}, {30'd0, e.mask});
            chk("hit0", {28'd0, hit_cnt_o[0 +: CW]}, {28'd0, e.h0});
            chk("hit1", {28'd0, hit_cnt_o[CW +: CW]}, {28'd0, e.h1});
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk_i);
            n++;
        end
        #2;
        chk("drain", q.size(), 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_pend", {31'd0, entry_pending_o}, 0);
        chk("rst_pulse", {26'd0, entry_ok_o, dpc_err_o, cause_err_o, missed_err_o, timeout_err_o, spurious_err_o}, 0);
        chk("rst_hits", {24'd0, hit_cnt_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Execute trigger 0, correct entry
        drive(1, 0, 3'd0, 32'h0000_2000, 32'h0, 2'b01, 2'b00, 2'b00, P_NONE, 1, 2'b01);
        dentry(3'd2, 32'h0000_2000, P_OK);
        plain(P_NONE);

        // Load trigger 1, wrong dpc
        drive(1, 0, 3'd0, 32'h0000_3004, 32'h0, 2'b00, 2'b10, 2'b00, P_NONE, 1, 2'b10);
        dentry(3'd2, 32'h0000_3008, P_DPC);
        // Matches during debug are not captured
        drive(1, 1, 3'd0, 32'h1A11_0804, 32'h0, 2'b01, 2'b00, 2'b00, P_NONE, 0, 2'b00);
        // Capture on the first instruction after dret
        drive(1, 0, 3'd0, 32'h0000_4000, 32'h0, 2'b01, 2'b00, 2'b00, P_NONE, 1, 2'b01);
        // Wrong cause
        dentry(3'd3, 32'h0000_4000, P_CAU);
        plain(P_NONE);

        // Exception trigger: dpc not compared
        drive(1, 0, 3'd0, 32'h0000_5000, 32'h0, 2'b00, 2'b00, 2'b01, P_NONE, 1, 2'b01);
        dentry(3'd2, 32'h0000_1234, P_OK);
        plain(P_NONE);

        // Missed entry with recapture, then timeout measured from the recapture
        drive(1, 0, 3'd0, 32'h0000_6000, 32'h0, 2'b01, 2'b00, 2'b00, P_NONE, 1, 2'b01);
        idle(P_NONE, 1, 2'b01);
        idle(P_NONE, 1, 2'b01);
        drive(1, 0, 3'd0, 32'h0000_6004, 32'h0, 2'b10, 2'b00, 2'b00, P_MIS, 1, 2'b10);
        for (int i = 0; i < TMO - 1; i++) idle(P_NONE, 1, 2'b10);
        idle(P_TMO, 0, 2'b00);
        idle(P_NONE, 0, 2'b00);

        // Missed entry without recapture
        drive(1, 0, 3'd0, 32'h0000_7000, 32'h0, 2'b01, 2'b00, 2'b00, P_NONE, 1, 2'b01);
        plain(P_MIS);

        // Entry in the timeout cycle wins over the timeout
        drive(1, 0, 3'd0, 32'h0000_8000, 32'h0, 2'b01, 2'b00, 2'b00, P_NONE, 1, 2'b01);
        for (int i = 0; i < TMO - 1; i++) idle(P_NONE, 1, 2'b01);
        dentry(3'd2, 32'h0000_8000, P_OK);
        idle(P_NONE, 0, 2'b00);
        plain(P_NONE);

        // Spurious trigger entry, then a silent haltreq entry
        dentry(3'd2, 32'h0000_0000, P_SPU);
        dentry(3'd0, 32'h0000_0000, P_NONE);
        plain(P_NONE);
        dentry(3'd3, 32'h0000_0000, P_NONE);
        plain(P_NONE);

        // Both triggers in one retirement
        drive(1, 0, 3'd0, 32'h0000_9000, 32'h0, 2'b11, 2'b00, 2'b00, P_NONE, 1, 2'b11);
        dentry(3'd2, 32'h0000_9000, P_OK);
        plain(P_NONE);

        // Reset while waiting for the entry
        drive(1, 0, 3'd0, 32'h0000_A000, 32'h0, 2'b01, 2'b00, 2'b00, P_NONE, 1, 2'b01);
        drain();
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("arst_pend", {31'd0, entry_pending_o}, 0);
        chk("arst_mask", {30'd0, pending_mask_o}, 0);
        chk("arst_hits", {24'd0, hit_cnt_o}, 0);
        e_hit0 = 0;
        e_hit1 = 0;
        dentry(3'd2, 32'h0000_A000, P_NONE);
        idle(P_NONE, 0, 2'b00);
        rst_ni = 1'b1;
        idle(P_NONE, 0, 2'b00);
        idle(P_NONE, 0, 2'b00);

        // Counter saturation: 17 back-to-back captures of trigger 0
        for (int i = 0; i < HMAX + 2; i++) begin
            drive(1, 0, 3'd0, 32'h0000_B000 + 32'(i * 4), 32'h0, 2'b01, 2'b00, 2'b00,
                  (i == 0) ? P_NONE : P_MIS, 1, 2'b01);
        end
        plain(P_MIS);
        idle(P_NONE, 0, 2'b00);

        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uvmt_cv32e40x_sl_trigger_entry_checker.md
Name: uvmt_cv32e40x_sl_trigger_entry_checker

Overview:
Support-logic stage directly downstream of the trigger-match predictor. It consumes the per-retirement trigger-match vectors and tracks the expected debug-mode entry caused by each match. It also flags missing, mismatched, late or spurious trigger debug entries, and keeps per-trigger hit counters that assertions and coverage use.

Parameters:
NUM_TRIGGERS, 1, number of debug triggers (matches CORE_PARAM_DBG_NUM_TRIGGERS)
TIMEOUT_CYCLES, 64, max cycles from trigger match to debug-handler retirement
CNT_W, 16, width of each per-trigger hit counter

Ports:
clk_i  input  1  core clock
rst_ni  input  1  asynchronous active-low reset
rvfi_valid_i  input  1  instruction retirement strobe
rvfi_dbg_mode_i  input  1  retired instruction executed in debug mode
rvfi_dbg_i  input  3  debug cause of retirement; non-zero only on the first debug-handler instruction
rvfi_pc_rdata_i  input  32  PC of retired instruction
dpc_i  input  32  dpc CSR value sampled at retirement
trigger_match_execute_i  input  NUM_TRIGGERS  execute matches from upstream
trigger_match_mem_i  input  NUM_TRIGGERS  load/store matches from upstream
trigger_match_exception_i  input  NUM_TRIGGERS  exception-trigger matches from upstream
entry_pending_o  output  1  trigger debug entry expected, not yet seen
pending_mask_o  output  NUM_TRIGGERS  triggers captured for the pending entry
entry_ok_o  output  1  pulse: correct trigger debug entry
dpc_err_o  output  1  pulse: entry seen with wrong dpc
cause_err_o  output  1  pulse: debug entry after match with cause != 2
missed_err_o  output  1  pulse: non-debug retirement while entry pending
timeout_err_o  output  1  pulse: TIMEOUT_CYCLES elapsed while pending
spurious_err_o  output  1  pulse: cause-2 entry with no pending match
hit_cnt_o  output  NUM_TRIGGERS*CNT_W  saturating per-trigger hit counters, trigger t at [t*CNT_W +: CNT_W]

Behaviour:
- Reset (async, rst_ni=0): state IDLE, all outputs 0, counters 0, captured PC 0. Release is synchronous to the next clk_i edge.
- match = (execute|mem|exception vectors ORed); a capture event is rvfi_valid_i && !rvfi_dbg_mode_i && |match. Upstream already suppresses mem matches when execute/exception match.
- FSM states:
  - IDLE:
    - On capture: latch pending_mask=match, exp_pc=rvfi_pc_rdata_i, chk_pc = !(|exception vector). Clear the cycle counter, go to WAIT_ENTRY.
    - On rvfi_valid_i && rvfi_dbg_mode_i && rvfi_dbg_i==2: spurious_err_o pulse, go to IN_DEBUG.
    - On any other debug entry (cause != 2, e.g. haltreq): go to IN_DEBUG silently.
  - WAIT_ENTRY:
    - The counter increments every cycle. If the counter reaches TIMEOUT_CYCLES-1 with no resolving retirement: timeout_err_o pulse, go to IDLE.
    - On rvfi_valid_i && rvfi_dbg_mode_i:
      - rvfi_dbg_i==2 and (!chk_pc or dpc_i==exp_pc): entry_ok_o pulse.
      - rvfi_dbg_i==2 with dpc mismatch: dpc_err_o pulse.
      - rvfi_dbg_i!=2: cause_err_o pulse.
      - In all three cases go to IN_DEBUG.
    - On rvfi_valid_i && !rvfi_dbg_mode_i: missed_err_o pulse. If this retirement is itself a capture event, recapture and stay in WAIT_ENTRY with the counter cleared; otherwise go to IDLE.
    - Priority: a resolving retirement in the timeout cycle wins; timeout_err_o does not fire.
  - IN_DEBUG:
    - Matches are ignored because upstream gates them on !dbg_mode; any that still arrive are ignored here.
    - On rvfi_valid_i && !rvfi_dbg_mode_i: go to IDLE and evaluate that same retirement as in IDLE, so a capture on the first instruction after dret is accepted.
- entry_pending_o = (state==WAIT_ENTRY); pending_mask_o is held in WAIT_ENTRY and zero otherwise.
- All *_err_o and entry_ok_o are registered single-cycle pulses, asserted the cycle after the causing retirement. At most one pulse fires per cycle.
- Hit counters: on each capture event, every counter t with match[t]=1 increments by 1. Counters saturate at 2^CNT_W-1 (no wrap). Several counters may increment in the same cycle.
- Exception triggers: dpc is not compared (chk_pc=0); only the cause is checked.

Test Plan:
- Execute trigger 0 at PC 0x0000_2000, next retirement debug with cause 2 and dpc 0x2000 -> entry_ok_o pulse, hit_cnt[0]=1, entry_pending_o falls.
- Load trigger 1 match at PC 0x3004, debug entry with dpc 0x3008 -> dpc_err_o pulse, state IN_DEBUG.
- Match captured, no retirement for TIMEOUT_CYCLES=64 cycles -> timeout_err_o on cycle 64, state IDLE; debug entry arriving in cycle 63 instead -> entry_ok_o, no timeout.
- Match captured, then non-debug retirement that also matches trigger 0 -> missed_err_o pulse, pending_mask_o updated, counter restarted.
- Debug retirement with cause 2 while IDLE -> spurious_err_o; rst_ni low while WAIT_ENTRY -> all outputs 0 immediately, no pulse after release.
- Force hit_cnt[0] to 0xFFFF with CNT_W=16, apply another match -> hit_cnt[0] stays 0xFFFF.
